// File: rtl/cva6_clic_irq_arbiter.sv
// Interrupt arbiter ahead of the CVA6 CLIC: picks the best pending source, offers it
// over a valid/ready handshake, revokes stale offers via kill req/ack, and pulses a claim.
module cva6_clic_irq_arbiter #(
  parameter int unsigned NumSrc  = 64,
  parameter int unsigned IdWidth = $clog2(NumSrc)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumSrc-1:0]     irq_pending_i,
  input  logic [NumSrc-1:0]     irq_enable_i,
  input  logic [NumSrc*8-1:0]   irq_level_i,
  input  logic [NumSrc*2-1:0]   irq_priv_i,
  output logic [NumSrc-1:0]     irq_claim_o,
  output logic                  clic_irq_valid_o,
  input  logic                  clic_irq_ready_i,
  output logic [IdWidth-1:0]    clic_irq_id_o,
  output logic [7:0]            clic_irq_level_o,
  output logic [1:0]            clic_irq_priv_o,
  output logic                  clic_kill_req_o,
  input  logic                  clic_kill_ack_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    KILL  = 2'd2
  } state_e;

  state_e               state_r;
  state_e               state_next_s;
  logic [NumSrc-1:0]    elig_s;
  logic                 cand_valid_s;
  logic [IdWidth-1:0]   cand_id_s;
  logic [9:0]           cand_rank_s;
  logic [IdWidth-1:0]   id_r;
  logic [7:0]           level_r;
  logic [1:0]           priv_r;
  logic                 load_s;
  logic                 offer_elig_s;
  logic                 better_s;
  logic [NumSrc-1:0]    claim_s;

  // Per-source eligibility; privilege encoding 2 is reserved and never wins
  always_comb begin
    elig_s = {NumSrc{1'b0}};
    for (int i = 0; i < int'(NumSrc); i++) begin
      elig_s[i] = irq_pending_i[i] & irq_enable_i[i]
                & (irq_level_i[8*i +: 8] != 8'd0)
                & (irq_priv_i[2*i +: 2] != 2'd2);
    end
  end

  // Highest {priv, level}; strict compare in ascending order keeps the lowest ID on ties
  always_comb begin
    cand_valid_s = 1'b0;
    cand_id_s    = {IdWidth{1'b0}};
    cand_rank_s  = 10'd0;
    for (int i = 0; i < int'(NumSrc); i++) begin
      if (elig_s[i] && (!cand_valid_s ||
          ({irq_priv_i[2*i +: 2], irq_level_i[8*i +: 8]} > cand_rank_s))) begin
        cand_valid_s = 1'b1;
        cand_id_s    = IdWidth'(i);
        cand_rank_s  = {irq_priv_i[2*i +: 2], irq_level_i[8*i +: 8]};
      end else begin
        cand_valid_s = cand_valid_s;
      end
    end
  end

  assign offer_elig_s = elig_s[id_r];
  assign better_s     = cand_valid_s && (cand_rank_s > {priv_r, level_r});

  // Next-state, offer load strobe and claim pulse
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    claim_s      = {NumSrc{1'b0}};
    case (state_r)
      IDLE: begin
        if (cand_valid_s) begin
          load_s       = 1'b1;
          state_next_s = OFFER;
        end else begin
          state_next_s = IDLE;
        end
      end
      OFFER: begin
        if (clic_irq_ready_i) begin
          claim_s      = {{(NumSrc-1){1'b0}}, 1'b1} << id_r;
          state_next_s = IDLE;
        end else if (!offer_elig_s || better_s) begin
          state_next_s = KILL;
        end else begin
          state_next_s = OFFER;
        end
      end
      KILL: begin
        // A late accept still wins over the revoke acknowledgement
        if (clic_irq_ready_i) begin
          claim_s      = {{(NumSrc-1){1'b0}}, 1'b1} << id_r;
          state_next_s = IDLE;
        end else if (clic_kill_ack_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = KILL;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Offer registers, frozen from IDLE->OFFER until the return to IDLE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_r    <= {IdWidth{1'b0}};
      level_r <= 8'd0;
      priv_r  <= 2'd0;
    end else if (load_s) begin
      id_r    <= cand_id_s;
      level_r <= cand_rank_s[7:0];
      priv_r  <= cand_rank_s[9:8];
    end else begin
      id_r    <= id_r;
      level_r <= level_r;
      priv_r  <= priv_r;
    end
  end

  assign clic_irq_valid_o = (state_r == OFFER);
  assign clic_kill_req_o  = (state_r == KILL);
  assign clic_irq_id_o    = id_r;
  assign clic_irq_level_o = level_r;
  assign clic_irq_priv_o  = priv_r;
  assign irq_claim_o      = claim_s;

endmodule
